// File: rtl/b_lut_seq.sv
// ---------------------------------------------------------------------------
// b_lut_seq
//   Multi-beat sequencer feeding the combinational b_lut stage (nibble-wise
//   4-bit substitution). A request carries a DWIDTH-bit operand and a 64-bit
//   LUT. The operand is streamed through b_lut one 32-bit slice per cycle and
//   each result is written back in place. The whole operand is substituted
//   PASSES times before the result is offered on the response channel.
//
// Ports
//   clock        in   system clock, all state changes on posedge
//   resetn       in   synchronous reset, active-low (priority over flush)
//   flush        in   synchronous abort back to IDLE (priority over handshakes)
//   req_valid    in   request present
//   req_ready    out  request accepted when high (IDLE only)
//   req_data     in   DWIDTH-bit operand, nibble i indexes the LUT
//   req_lut_lo   in   LUT entries 0..7  (entry i = bits 4i+3:4i)
//   req_lut_hi   in   LUT entries 8..15
//   lut_crs1     out  current 32-bit slice to b_lut (0 outside RUN)
//   lut_crs2     out  latched LUT low half to b_lut
//   lut_crs3     out  latched LUT high half to b_lut
//   lut_result   in   b_lut result, combinational in the same cycle
//   rsp_valid    out  result available (DONE)
//   rsp_ready    in   consumer accepts result
//   rsp_data     out  substituted operand (meaningful while rsp_valid=1)
// ---------------------------------------------------------------------------
module b_lut_seq #(
  parameter int unsigned DWIDTH = 64,
  parameter int unsigned PASSES = 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DWIDTH-1:0] req_data,
  input  logic [31:0]       req_lut_lo,
  input  logic [31:0]       req_lut_hi,
  output logic [31:0]       lut_crs1,
  output logic [31:0]       lut_crs2,
  output logic [31:0]       lut_crs3,
  input  logic [31:0]       lut_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_data
);

  localparam int unsigned BEATS = DWIDTH / 32;
  localparam int unsigned BW    = (BEATS  > 1) ? $clog2(BEATS)  : 1;
  localparam int unsigned PW    = (PASSES > 1) ? $clog2(PASSES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [DWIDTH-1:0] work;
  logic [31:0]       tbl_lo;
  logic [31:0]       tbl_hi;
  logic [BW-1:0]     beat_cnt;
  logic [PW-1:0]     pass_cnt;

  logic [31:0]       slice;
  logic              last_beat;
  logic              last_pass;
  logic              accept;

  assign last_beat = (beat_cnt == BW'(BEATS - 1));
  assign last_pass = (pass_cnt == PW'(PASSES - 1));
  assign accept    = req_valid && req_ready;

  // Slice selection as an explicit mux over beats keeps index widths exact.
  always_comb begin
    slice = '0;
    for (int unsigned b = 0; b < BEATS; b++) begin
      if (beat_cnt == BW'(b)) begin
        slice = work[32*b +: 32];
      end
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and output decode
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    lut_crs1   = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          next_state = RUN;
        end
      end
      RUN: begin
        lut_crs1 = slice;
        if (last_beat && last_pass) begin
          next_state = DONE;
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    if (flush) begin
      next_state = IDLE;
    end
  end

  // Datapath: operand, table and beat/pass counters
  always_ff @(posedge clock) begin
    if (!resetn) begin
      work     <= '0;
      tbl_lo   <= '0;
      tbl_hi   <= '0;
      beat_cnt <= '0;
      pass_cnt <= '0;
    end else if (flush) begin
      // Abort keeps the operand and table; only sequencing restarts.
      beat_cnt <= '0;
      pass_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            work     <= req_data;
            tbl_lo   <= req_lut_lo;
            tbl_hi   <= req_lut_hi;
            beat_cnt <= '0;
            pass_cnt <= '0;
          end
        end
        RUN: begin
          for (int unsigned b = 0; b < BEATS; b++) begin
            if (beat_cnt == BW'(b)) begin
              work[32*b +: 32] <= lut_result;
            end
          end
          if (last_beat) begin
            beat_cnt <= '0;
            if (!last_pass) begin
              pass_cnt <= pass_cnt + PW'(1);
            end else begin
              pass_cnt <= '0;
            end
          end else begin
            beat_cnt <= beat_cnt + BW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign lut_crs2 = tbl_lo;
  assign lut_crs3 = tbl_hi;
  assign rsp_data = work;

endmodule
